scan_top: RTL and testbench
===========================

Name: scan_top

Overview:
- Scan-sequence controller for the NMR acquisition front end.
- Holds a small bank of 16-bit timing registers loaded from the host bus (datain/scanload).
- On a start request it plays one scan: DDS configuration, then N echo cycles of RF switch → dump-on → acquisition.
- Raises a one-cycle interrupt when the scan finishes and drives the analog-switch/dump/calibration control lines.

Parameters:
- W, 16, width of datain and of every timing register.
- NREG, 5, number of load-pointer slots (indices 0..4).

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- scanrst  in  1  reset; synchronous, active-high.
- scanstart  in  1  start request; rising edge detected internally.
- scanload  in  1  load strobe; writes datain to the register at the load pointer.
- scanchoice  in  1  mode: 0 = normal acquisition, 1 = calibration scan.
- datain  in  16  register load data.
- interrupt  out  1  one-cycle pulse at end of scan.
- dds_conf  out  1  high during the DDS phase.
- rt_sw  out  1  high during the RT phase.
- dumpon_ctr  out  1  high during the DUMP phase.
- dumpoff_ctr  out  1  high during the ACQ phase.
- s_acq  out  1  high during the ACQ phase.
- sw_acq1  out  1  high during ACQ when scanchoice latched = 0.
- sw_acq2  out  1  high during ACQ when scanchoice latched = 1.
- calctrl  out  1  high for the whole scan (DDS..DONE) when latched scanchoice = 1.
- soft_d  out  1  busy flag; high from DDS through DONE inclusive.

Behaviour:
- Reset (scanrst = 1 at a clock edge):
  - all outputs 0, FSM to IDLE, load pointer 0.
  - all timing registers set to 16'h0001; echo counter 0; start edge detector cleared.
  - Reset mid-scan aborts immediately; no interrupt is issued.
- Registers, by load-pointer index: 0 T_DDS, 1 T_RT, 2 T_DUMP, 3 T_ACQ, 4 N_ECHO.
- Load:
  - When IDLE and scanload = 1 at a clock edge, reg[ptr] <= datain and ptr <= ptr+1.
  - The pointer wraps 4 → 0.
  - scanload is ignored while not IDLE (pointer also unchanged).
  - scanload held high loads on every cycle.
- Start:
  - start_pulse = scanstart & ~scanstart_q, where scanstart_q is the registered previous value.
  - Accepted only in IDLE; ignored while busy.
  - On accept, scanchoice is latched for the scan.
- A register value of 0 is treated as 1, for both lengths and N_ECHO.
- FSM states: IDLE, DDS, RT, DUMP, ACQ, DONE.
  - IDLE → DDS on an accepted start.
  - DDS lasts T_DDS cycles, then RT.
  - RT lasts T_RT cycles, then DUMP.
  - DUMP lasts T_DUMP cycles, then ACQ.
  - ACQ lasts T_ACQ cycles. Echo counter increments at ACQ end; if the count < N_ECHO go to RT, else go to DONE.
  - DONE lasts 1 cycle (interrupt = 1), then IDLE.
- Timing:
  - Outputs are registered and decoded from the state.
  - If the start edge is sampled at edge k, dds_conf is high from edge k+1.
  - Total busy time = T_DDS + N_ECHO*(T_RT + T_DUMP + T_ACQ) + 1 cycles.
- Exactly one phase output (dds_conf / rt_sw / dumpon_ctr / ACQ group) is high at any time. There are no gap cycles between phases.
- Phase counters are 16-bit down-counters loaded at phase entry. The echo counter is 16-bit.
- A new start on the same cycle as DONE is ignored. A start is accepted only when the FSM is in IDLE.

Test Plan:
- Reset → all outputs 0. Then pulse scanstart without any load → defaults of 1 → dds_conf, rt_sw, dumpon_ctr, s_acq each high 1 cycle, interrupt on cycle 5, soft_d high 5 cycles.
- Load 3,2,4,5,2 (five scanload cycles), scanchoice = 0, start → dds_conf 3 cycles, then twice (rt_sw 2, dumpon_ctr 4, s_acq/sw_acq1/dumpoff_ctr 5), interrupt 1 cycle; busy 26 cycles; sw_acq2 and calctrl stay 0.
- Same registers with scanchoice = 1 → sw_acq2 replaces sw_acq1; calctrl high for all 26 cycles; sw_acq1 stays 0.
- Six scanload writes (values 10..15) → reg0 = 15 (pointer wrap), reg1..4 = 11..14; scanload during busy leaves the registers unchanged.
- Held-high scanstart and a second edge mid-scan → exactly one scan and one interrupt. Load datain = 0 into T_RT → RT lasts 1 cycle.
- scanrst asserted during ACQ → next cycle all outputs 0, no interrupt; the following start runs a full scan with the reset registers (all 1).

Source files
------------

// File: rtl/scan_top.sv
// -----------------------------------------------------------------------------
// scan_top -- scan-sequence controller for the NMR acquisition front end.
//
// A bank of NREG timing registers is written from the host bus through an
// auto-incrementing load pointer. A rising edge on scanstart plays one scan:
//   DDS -> { RT -> DUMP -> ACQ } x N_ECHO -> DONE -> IDLE
// Each phase length comes from its register. A register value of 0 is
// treated as 1.
//
// Ports
//   clk_sys      in   system clock, rising edge
//   scanrst      in   synchronous active-high reset
//   scanstart    in   start request (rising edge detected internally)
//   scanload     in   load strobe: reg[ptr] <= datain, ptr++ (IDLE only)
//   scanchoice   in   0 = normal acquisition, 1 = calibration (latched at start)
//   datain       in   register load data
//   interrupt    out  one-cycle pulse at end of scan
//   dds_conf     out  DDS phase
//   rt_sw        out  RT phase
//   dumpon_ctr   out  DUMP phase
//   dumpoff_ctr  out  ACQ phase
//   s_acq        out  ACQ phase
//   sw_acq1      out  ACQ phase, normal mode
//   sw_acq2      out  ACQ phase, calibration mode
//   calctrl      out  whole scan, calibration mode
//   soft_d       out  busy, DDS through DONE
// -----------------------------------------------------------------------------
module scan_top #(
  parameter int W    = 16,
  parameter int NREG = 5
) (
  input  logic         clk_sys,
  input  logic         scanrst,
  input  logic         scanstart,
  input  logic         scanload,
  input  logic         scanchoice,
  input  logic [W-1:0] datain,
  output logic         interrupt,
  output logic         dds_conf,
  output logic         rt_sw,
  output logic         dumpon_ctr,
  output logic         dumpoff_ctr,
  output logic         s_acq,
  output logic         sw_acq1,
  output logic         sw_acq2,
  output logic         calctrl,
  output logic         soft_d
);

  localparam int PTR_W = $clog2(NREG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DDS  = 3'd1,
    S_RT   = 3'd2,
    S_DUMP = 3'd3,
    S_ACQ  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]     echo_q, echo_d;
  logic             choice_q, choice_d;
  logic             scanstart_q;
  logic [PTR_W-1:0] ptr_q;
  logic [W-1:0]     regs_q [NREG];

  logic start_pulse;
  logic load_en;

  assign start_pulse = scanstart & ~scanstart_q;
  assign load_en     = scanload & (state_q == S_IDLE);

  // ---------------------------------------------------------------------------
  // Timing register bank and load pointer
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    always_ff @(posedge clk_sys) begin
      if (scanrst) begin
        regs_q[gi] <= W'(1);
      end else if (load_en && (ptr_q == PTR_W'(gi))) begin
        regs_q[gi] <= datain;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (scanrst) begin
      ptr_q       <= '0;
      scanstart_q <= 1'b0;
    end else begin
      scanstart_q <= scanstart;
      if (load_en) begin
        ptr_q <= (ptr_q == PTR_W'(NREG - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
    end
  end

  // Zero-valued registers behave as 1 so every phase lasts at least a cycle.
  function automatic logic [W-1:0] eff_len(input logic [W-1:0] v);
    return (v == '0) ? W'(1) : v;
  endfunction

  logic [W-1:0] t_dds, t_rt, t_dump, t_acq, n_echo;
  assign t_dds  = eff_len(regs_q[0]);
  assign t_rt   = eff_len(regs_q[1]);
  assign t_dump = eff_len(regs_q[2]);
  assign t_acq  = eff_len(regs_q[3]);
  assign n_echo = eff_len(regs_q[4]);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (scanrst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      echo_q   <= '0;
      choice_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      echo_q   <= echo_d;
      choice_q <= choice_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. cnt_q holds the cycles remaining in the current phase,
  // loaded at phase entry, so a phase ends when it reaches 1.
  // ---------------------------------------------------------------------------
  logic last_cycle;
  logic more_echoes;
  assign last_cycle  = (cnt_q <= W'(1));
  // Widened compare keeps echo_q + 1 from wrapping at the top of the range.
  assign more_echoes = (({1'b0, echo_q} + (W + 1)'(1)) < {1'b0, n_echo});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    echo_d   = echo_q;
    choice_d = choice_q;
    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          state_d  = S_DDS;
          cnt_d    = t_dds;
          echo_d   = '0;
          choice_d = scanchoice;
        end
      end
      S_DDS: begin
        if (last_cycle) begin
          state_d = S_RT;
          cnt_d   = t_rt;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      S_RT: begin
        if (last_cycle) begin
          state_d = S_DUMP;
          cnt_d   = t_dump;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      S_DUMP: begin
        if (last_cycle) begin
          state_d = S_ACQ;
          cnt_d   = t_acq;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      S_ACQ: begin
        if (last_cycle) begin
          echo_d = echo_q + W'(1);
          if (more_echoes) begin
            state_d = S_RT;
            cnt_d   = t_rt;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode from the current state, then registered. This puts the
  // first dds_conf cycle one edge after the start edge is sampled.
  // ---------------------------------------------------------------------------
  logic intr_d, dds_d, rt_d, dump_d, acq_d, sw1_d, sw2_d, cal_d, busy_d;
  logic intr_q, dds_q, rt_q, dump_q, acq_q, sw1_q, sw2_q, cal_q, busy_q;

  always_comb begin
    intr_d = 1'b0;
    dds_d  = 1'b0;
    rt_d   = 1'b0;
    dump_d = 1'b0;
    acq_d  = 1'b0;
    sw1_d  = 1'b0;
    sw2_d  = 1'b0;
    busy_d = (state_q != S_IDLE);
    cal_d  = (state_q != S_IDLE) & choice_q;
    case (state_q)
      S_DDS:  dds_d  = 1'b1;
      S_RT:   rt_d   = 1'b1;
      S_DUMP: dump_d = 1'b1;
      S_ACQ: begin
        acq_d = 1'b1;
        sw1_d = ~choice_q;
        sw2_d = choice_q;
      end
      S_DONE: intr_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (scanrst) begin
      intr_q <= 1'b0;
      dds_q  <= 1'b0;
      rt_q   <= 1'b0;
      dump_q <= 1'b0;
      acq_q  <= 1'b0;
      sw1_q  <= 1'b0;
      sw2_q  <= 1'b0;
      cal_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      intr_q <= intr_d;
      dds_q  <= dds_d;
      rt_q   <= rt_d;
      dump_q <= dump_d;
      acq_q  <= acq_d;
      sw1_q  <= sw1_d;
      sw2_q  <= sw2_d;
      cal_q  <= cal_d;
      busy_q <= busy_d;
    end
  end

  assign interrupt   = intr_q;
  assign dds_conf    = dds_q;
  assign rt_sw       = rt_q;
  assign dumpon_ctr  = dump_q;
  assign dumpoff_ctr = acq_q;
  assign s_acq       = acq_q;
  assign sw_acq1     = sw1_q;
  assign sw_acq2     = sw2_q;
  assign calctrl     = cal_q;
  assign soft_d      = busy_q;

endmodule

// File: tb/tb_scan_top.sv
// -----------------------------------------------------------------------------
// tb_scan_top -- self-checking bench for scan_top.
// Expected per-cycle output vectors are pushed to a queue when a scan is
// launched and popped/compared one per clock as the DUT plays the scan.
// Output vector bits: [9] interrupt [8] dds_conf [7] rt_sw [6] dumpon_ctr
// [5] dumpoff_ctr [4] s_acq [3] sw_acq1 [2] sw_acq2 [1] calctrl [0] soft_d
// -----------------------------------------------------------------------------
module tb_scan_top;

  logic        clk_sys = 1'b0;
  logic        scanrst;
  logic        scanstart;
  logic        scanload;
  logic        scanchoice;
  logic [15:0] datain;
  logic        interrupt, dds_conf, rt_sw, dumpon_ctr, dumpoff_ctr;
  logic        s_acq, sw_acq1, sw_acq2, calctrl, soft_d;

  scan_top #(.W(16), .NREG(5)) dut (
    .clk_sys     (clk_sys),
    .scanrst     (scanrst),
    .scanstart   (scanstart),
    .scanload    (scanload),
    .scanchoice  (scanchoice),
    .datain      (datain),
    .interrupt   (interrupt),
    .dds_conf    (dds_conf),
    .rt_sw       (rt_sw),
    .dumpon_ctr  (dumpon_ctr),
    .dumpoff_ctr (dumpoff_ctr),
    .s_acq       (s_acq),
    .sw_acq1     (sw_acq1),
    .sw_acq2     (sw_acq2),
    .calctrl     (calctrl),
    .soft_d      (soft_d)
  );

  always #5 clk_sys = ~clk_sys;

  logic [9:0] outv;
  assign outv = {interrupt, dds_conf, rt_sw, dumpon_ctr, dumpoff_ctr,
                 s_acq, sw_acq1, sw_acq2, calctrl, soft_d};

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q [$];
  int         mreg [5];
  int         mptr;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // ph: 0 idle, 1 DDS, 2 RT, 3 DUMP, 4 ACQ, 5 DONE
  function automatic logic [9:0] vec(input int ph, input logic ch);
    logic [9:0] v;
    v = '0;
    if (ph != 0) begin
      v[0] = 1'b1;
      v[1] = ch;
    end
    case (ph)
      1: v[8] = 1'b1;
      2: v[7] = 1'b1;
      3: v[6] = 1'b1;
      4: begin
        v[5] = 1'b1;
        v[4] = 1'b1;
        v[3] = ~ch;
        v[2] = ch;
      end
      5: v[9] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic load(input int val);
    scanload = 1'b1;
    datain   = 16'(val);
    tick();
    scanload = 1'b0;
    mreg[mptr] = val;
    mptr = (mptr == 4) ? 0 : mptr + 1;
    $display("load ptr-model=%0d value=%0d", mptr, val);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) mreg[i] = 1;
    mptr = 0;
  endtask

  // mode: 0 = pulse start, 1 = hold start high, 2 = second edge mid-scan
  // busy_load: pulse scanload with junk data while the scan runs
  task automatic run_scan(input logic ch, input int mode, input logic busy_load);
    int tdds, trt, tdump, tacq, nech, busy_exp, busy_cnt, k;
    logic [9:0] e;
    tdds  = eff(mreg[0]);
    trt   = eff(mreg[1]);
    tdump = eff(mreg[2]);
    tacq  = eff(mreg[3]);
    nech  = eff(mreg[4]);
    busy_exp = tdds + nech * (trt + tdump + tacq) + 1;
    for (int i = 0; i < tdds; i++) exp_q.push_back(vec(1, ch));
    for (int n = 0; n < nech; n++) begin
      for (int i = 0; i < trt; i++)   exp_q.push_back(vec(2, ch));
      for (int i = 0; i < tdump; i++) exp_q.push_back(vec(3, ch));
      for (int i = 0; i < tacq; i++)  exp_q.push_back(vec(4, ch));
    end
    exp_q.push_back(vec(5, ch));
    for (int i = 0; i < 3; i++) exp_q.push_back(vec(0, ch));

    scanchoice = ch;
    scanstart  = 1'b1;
    tick();
    check("pre_start", outv, '0);
    scanchoice = ~ch;  // must have been latched at accept
    k = 0;
    busy_cnt = 0;
    while (exp_q.size() > 0) begin
      if (mode == 0 && k == 0) scanstart = 1'b0;
      if (mode == 2) begin
        if (k == 0) scanstart = 1'b0;
        if (k == 2) scanstart = 1'b1;
        if (k == 4) scanstart = 1'b0;
      end
      if (busy_load && k == 3) begin
        scanload = 1'b1;
        datain   = 16'h00AA;
      end
      if (k == 5) scanload = 1'b0;
      tick();
      e = exp_q.pop_front();
      check("scan_cycle", outv, e);
      if (soft_d === 1'b1) busy_cnt++;
      k++;
    end
    scanstart = 1'b0;
    scanload  = 1'b0;
    check_int("busy_len", busy_cnt, busy_exp);
    tick();
    check("post_scan", outv, '0);
    $display("scan choice=%0d mode=%0d busy=%0d expected=%0d", ch, mode, busy_cnt, busy_exp);
  endtask

  initial begin
    bit found;
    scanrst    = 1'b1;
    scanstart  = 1'b0;
    scanload   = 1'b0;
    scanchoice = 1'b0;
    datain     = '0;
    model_reset();
    tick();
    tick();
    check("reset_outputs", outv, '0);
    scanrst = 1'b0;
    tick();
    check("idle_outputs", outv, '0);

    // defaults of 1
    run_scan(1'b0, 0, 1'b0);

    // 3,2,4,5,2 in both modes
    load(3); load(2); load(4); load(5); load(2);
    run_scan(1'b0, 0, 1'b0);
    run_scan(1'b1, 0, 1'b0);

    // six writes wrap the pointer; busy-time load must be ignored
    for (int v = 10; v <= 15; v++) load(v);
    run_scan(1'b0, 1, 1'b1);
    run_scan(1'b1, 2, 1'b0);

    // zero in T_RT, then zero in N_ECHO
    load(0); load(2); load(1); load(2); load(3);
    run_scan(1'b0, 0, 1'b0);
    load(1); load(1); load(1); load(0);
    run_scan(1'b1, 0, 1'b0);

    // reset during ACQ
    scanstart = 1'b1;
    tick();
    scanstart = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (s_acq === 1'b1) found = 1'b1;
    end
    check_int("reach_acq", int'(found), 1);
    scanrst = 1'b1;
    tick();
    check("reset_mid_scan", outv, '0);
    scanrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("after_abort", outv, '0);
    end
    model_reset();
    run_scan(1'b0, 0, 1'b0);
    load(2);  // pointer restarted at 0, so this is T_DDS
    run_scan(1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
